// File: rtl/volume_scaler_if.sv
// Sample stream, volume controls and gain-ROM connection for volume_scaler.
// The master side is the source/ROM; the slave side is the scaler itself.
interface volume_scaler_if #(
  parameter int SAMPLE_W = 16
);
  logic                       vol_up;
  logic                       vol_down;
  logic                       mute;
  logic signed [SAMPLE_W-1:0] sample_in;
  logic                       sample_in_valid;
  logic [3:0]                 rom_addr;
  logic [7:0]                 rom_dout;
  logic signed [SAMPLE_W-1:0] sample_out;
  logic                       sample_out_valid;
  logic [3:0]                 level;

  modport master (
    output vol_up, vol_down, mute, sample_in, sample_in_valid, rom_dout,
    input  rom_addr, sample_out, sample_out_valid, level
  );

  modport slave (
    input  vol_up, vol_down, mute, sample_in, sample_in_valid, rom_dout,
    output rom_addr, sample_out, sample_out_valid, level
  );
endinterface

// File: rtl/volume_scaler.sv
// Volume target/ramp control driving the linear gain ROM, plus a two-stage
// sample x gain datapath (capture, then multiply and drop the 8 fraction bits).
module volume_scaler #(
  parameter int SAMPLE_W = 16,
  parameter int RAMP_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  volume_scaler_if.slave bus
);
  localparam int              CW       = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int              PW       = SAMPLE_W + 9;
  localparam logic [CW-1:0]   CNT_LAST = CW'(RAMP_DIV - 1);
  localparam logic [3:0]      LVL_RST  = 4'd8;

  logic [3:0]                 target_q, target_d;
  logic [3:0]                 cur_q, cur_d;
  logic [3:0]                 eff_tgt;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       ramp_tick;

  logic signed [SAMPLE_W-1:0] s1_smp_q, s1_smp_d;
  logic [7:0]                 s1_gain_q, s1_gain_d;
  logic signed [SAMPLE_W-1:0] out_q, out_d;
  logic [1:0]                 vld_pipe_q, vld_pipe_d;

  logic signed [PW-1:0]       mul_a, mul_b, prod;
  logic                       unused_prod;

  // Simultaneous up/down cancel; saturate at both ends.
  always_comb begin
    target_d = target_q;
    if (bus.vol_up && !bus.vol_down && target_q != 4'd15)
      target_d = target_q + 4'd1;
    else if (bus.vol_down && !bus.vol_up && target_q != 4'd0)
      target_d = target_q - 4'd1;
  end

  assign eff_tgt   = bus.mute ? 4'd0 : target_q;
  assign ramp_tick = bus.sample_in_valid && (cnt_q == CNT_LAST);

  // The counter free-runs on accepts even when no step is pending, so a
  // retarget mid-ramp keeps the step cadence.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.sample_in_valid)
      cnt_d = ramp_tick ? '0 : cnt_q + CW'(1);
  end

  always_comb begin
    cur_d = cur_q;
    if (ramp_tick) begin
      if (cur_q < eff_tgt)
        cur_d = cur_q + 4'd1;
      else if (cur_q > eff_tgt)
        cur_d = cur_q - 4'd1;
    end
  end

  // rom_dout still reflects the pre-step level on the accept cycle.
  always_comb begin
    s1_smp_d  = s1_smp_q;
    s1_gain_d = s1_gain_q;
    if (bus.sample_in_valid) begin
      s1_smp_d  = bus.sample_in;
      s1_gain_d = bus.rom_dout;
    end
  end

  assign mul_a = {{9{s1_smp_q[SAMPLE_W-1]}}, s1_smp_q};
  assign mul_b = {{(SAMPLE_W+1){1'b0}}, s1_gain_q};
  assign prod  = mul_a * mul_b;
  assign unused_prod = ^{prod[PW-1], prod[7:0]};

  always_comb begin
    out_d = out_q;
    if (vld_pipe_q[0])
      out_d = prod[SAMPLE_W+7:8];
  end

  assign vld_pipe_d = {vld_pipe_q[0], bus.sample_in_valid};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      target_q   <= LVL_RST;
      cur_q      <= LVL_RST;
      cnt_q      <= '0;
      s1_smp_q   <= '0;
      s1_gain_q  <= '0;
      out_q      <= '0;
      vld_pipe_q <= '0;
    end else begin
      target_q   <= target_d;
      cur_q      <= cur_d;
      cnt_q      <= cnt_d;
      s1_smp_q   <= s1_smp_d;
      s1_gain_q  <= s1_gain_d;
      out_q      <= out_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  assign bus.rom_addr         = cur_q;
  assign bus.level            = cur_q;
  assign bus.sample_out       = out_q;
  assign bus.sample_out_valid = vld_pipe_q[1];
endmodule

// File: tb/tb_volume_scaler.sv
// Directed bench for volume_scaler with a gain = 17 x addr ROM, RAMP_DIV = 4,
// samples spaced 4 cycles apart.
module tb_volume_scaler;
  localparam int SW = 16;

  logic clk = 1'b0;
  logic reset_n;
  int   n_chk = 0;
  int   n_err = 0;

  volume_scaler_if #(.SAMPLE_W(SW)) bus ();

  volume_scaler #(.SAMPLE_W(SW), .RAMP_DIV(4)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Registered ROM model: dout valid one cycle after addr.
  always @(posedge clk) bus.rom_dout <= 8'(17 * bus.rom_addr);

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n             = 1'b0;
    bus.vol_up          = 1'b0;
    bus.vol_down        = 1'b0;
    bus.mute            = 1'b0;
    bus.sample_in       = '0;
    bus.sample_in_valid = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (2) tick();
  endtask

  // Accept in cycle n, expect the strobe in n+2 and a held output in n+3.
  task automatic send(input logic signed [SW-1:0] s, input int exp_out, input string tag);
    tick();
    bus.sample_in       = s;
    bus.sample_in_valid = 1'b1;
    tick();
    bus.sample_in_valid = 1'b0;
    tick();
    chk({tag, "_vld"}, bus.sample_out_valid, 1);
    chk({tag, "_out"}, bus.sample_out, exp_out);
    tick();
    chk({tag, "_vld_lo"}, bus.sample_out_valid, 0);
    chk({tag, "_hold"}, bus.sample_out, exp_out);
  endtask

  task automatic pulse(input bit up, input bit dn);
    bus.vol_up   = up;
    bus.vol_down = dn;
    tick();
    bus.vol_up   = 1'b0;
    bus.vol_down = 1'b0;
    tick();
  endtask

  initial begin
    int exp_o;
    int exp_l;

    // Reset values and basic latency
    do_reset();
    chk("rst_level", bus.level, 8);
    chk("rst_addr", bus.rom_addr, 8);
    chk("rst_out", bus.sample_out, 0);
    chk("rst_vld", bus.sample_out_valid, 0);
    send(16'sd1000, 531, "lat_pos");
    send(-16'sd1000, -532, "lat_neg");

    // Ramp up by three levels, stepping on accepts 4, 8, 12
    do_reset();
    repeat (3) pulse(1'b1, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      exp_o = (i <= 4) ? 531 : (i <= 8) ? 597 : (i <= 12) ? 664 : 730;
      exp_l = (i >= 12) ? 11 : (i >= 8) ? 10 : (i >= 4) ? 9 : 8;
      send(16'sd1000, exp_o, "ramp");
      chk("ramp_level", bus.level, exp_l);
    end

    // Saturation at 15 and at 0
    do_reset();
    repeat (10) pulse(1'b1, 1'b0);
    repeat (28) send(16'sd0, 0, "sat_hi_fill");
    chk("sat_hi_level", bus.level, 15);
    send(16'sd32767, 32639, "sat_max");
    send(-16'sd32768, -32640, "sat_min");
    repeat (20) pulse(1'b0, 1'b1);
    repeat (60) send(16'sd0, 0, "sat_lo_fill");
    chk("sat_lo_level", bus.level, 0);
    send(16'sd1000, 0, "sat_lo_out");

    // Simultaneous up/down, then mute down and back
    do_reset();
    pulse(1'b1, 1'b1);
    repeat (8) send(16'sd1000, 531, "both");
    chk("both_level", bus.level, 8);
    bus.mute = 1'b1;
    repeat (32) send(16'sd0, 0, "mute_fill");
    chk("mute_level", bus.level, 0);
    send(16'sd1000, 0, "mute_out");
    bus.mute = 1'b0;
    repeat (32) send(16'sd0, 0, "unmute_fill");
    chk("unmute_level", bus.level, 8);
    send(16'sd1000, 531, "unmute_out");

    // Reset one cycle after an accept
    do_reset();
    pulse(1'b1, 1'b0);
    repeat (4) send(16'sd1000, 531, "mf_pre");
    send(16'sd1000, 597, "mf_step");
    chk("mf_pre_level", bus.level, 9);
    tick();
    bus.sample_in       = -16'sd1000;
    bus.sample_in_valid = 1'b1;
    tick();
    bus.sample_in_valid = 1'b0;
    reset_n             = 1'b0;
    #1;
    chk("mf_level", bus.level, 8);
    chk("mf_addr", bus.rom_addr, 8);
    chk("mf_out", bus.sample_out, 0);
    chk("mf_vld", bus.sample_out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mf_no_strobe", bus.sample_out_valid, 0);
    end
    reset_n = 1'b1;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
